// File: rtl/audio_sample_fetcher.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : audio_sample_fetcher
// Description : Emits one 16-bit sample per sample_clk tick, fetching a 32-bit
//               flash word over Avalon-MM every second tick while walking a
//               circular word-address window. Optional macro: BACKWARD_PLAY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module audio_sample_fetcher #(
    parameter int                ADDR_W     = 23,
    parameter logic [ADDR_W-1:0] START_ADDR = '0,
    parameter logic [ADDR_W-1:0] END_ADDR   = 23'h7FFFF
) (
    input  logic              inclk,
    input  logic              Reset,
    input  logic              sample_clk,
    input  logic              play,
`ifdef BACKWARD_PLAY_EN
    input  logic              dir,
`endif
    output logic              mem_read,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_waitrequest,
    input  logic [31:0]       mem_readdata,
    input  logic              mem_readdatavalid,
    output logic [15:0]       audio_out,
    output logic              audio_valid,
    output logic              wrapped,
    output logic              overrun
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        REQ       = 2'd1,
        WAIT_DATA = 2'd2,
        WAIT_TICK = 2'd3
    } state_t;

    state_t            state;
    state_t            state_next;
    logic              s1;
    logic              s2;
    logic              tick;
    logic              start_word;
    logic              load_first;
    logic              load_second;
    logic              rev;
    logic [15:0]       second_half;
    logic [ADDR_W-1:0] step_addr;
    logic              step_wrap;

    assign tick = s1 & ~s2;

    always_comb begin
        state_next  = state;
        start_word  = 1'b0;
        load_first  = 1'b0;
        load_second = 1'b0;
        case (state)
            IDLE: begin
                if (tick && play) begin
                    state_next = REQ;
                    start_word = 1'b1;
                end
            end
            REQ: begin
                if (!mem_waitrequest) state_next = WAIT_DATA;
            end
            WAIT_DATA: begin
                if (mem_readdatavalid) begin
                    state_next = WAIT_TICK;
                    load_first = 1'b1;
                end
            end
            WAIT_TICK: begin
                if (tick && play) begin
                    state_next  = IDLE;
                    load_second = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign mem_read = (state == REQ);
    // A tick that lands while the fetch is still outstanding cannot be served.
    assign overrun  = tick & play & ((state == REQ) | (state == WAIT_DATA));

    always_comb begin
        if (rev) begin
            step_wrap = (mem_addr == START_ADDR);
            step_addr = step_wrap ? END_ADDR : mem_addr - 1'b1;
        end else begin
            step_wrap = (mem_addr == END_ADDR);
            step_addr = step_wrap ? START_ADDR : mem_addr + 1'b1;
        end
    end

`ifdef BACKWARD_PLAY_EN
    // Direction is frozen per word so a mid-word change applies to the next word.
    always_ff @(posedge inclk) begin
        if (Reset)           rev <= 1'b0;
        else if (start_word) rev <= dir;
    end
`else
    assign rev = 1'b0;
`endif

    always_ff @(posedge inclk) begin
        if (Reset) begin
            state       <= IDLE;
            s1          <= 1'b0;
            s2          <= 1'b0;
            mem_addr    <= START_ADDR;
            audio_out   <= 16'h0;
            audio_valid <= 1'b0;
            wrapped     <= 1'b0;
            second_half <= 16'h0;
        end else begin
            state       <= state_next;
            s1          <= sample_clk;
            s2          <= s1;
            audio_valid <= load_first | load_second;
            wrapped     <= 1'b0;
            if (load_first) begin
                audio_out   <= rev ? mem_readdata[31:16] : mem_readdata[15:0];
                second_half <= rev ? mem_readdata[15:0]  : mem_readdata[31:16];
            end
            if (load_second) begin
                audio_out <= second_half;
                mem_addr  <= step_addr;
                wrapped   <= step_wrap;
            end
        end
    end

endmodule
`default_nettype wire
